control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/proc_pkg.sv | 25 ++
 rtl/control_unit_if.sv | 15 +
 rtl/dec3to8.sv | 8 +
 rtl/control_unit.sv | 61 ++++++
 4 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: shared FSM state encoding, opcodes, ALU select codes and control bundle type
package proc_pkg;
  localparam logic [1:0] T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3;
  localparam logic [3:0] OP_MV = 4'd0, OP_MVI = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
                         OP_OR = 4'd4, OP_SLT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2,
                         ALU_SLT = 3'd3, ALU_SLL = 3'd4, ALU_SRL = 3'd5;
  typedef struct packed {
    logic [7:0] rout;
    logic [7:0] rin;
    logic       dinout;
    logic       gout;
    logic       ain;
    logic       gin;
    logic [2:0] alu_op;
    logic       done;
  } ctrl_t;
  function automatic logic is_alu(input logic [3:0] op);
    return !op[3] && op >= OP_ADD;
  endfunction
  function automatic logic [2:0] alu_code(input logic [3:0] op);
    return op == OP_SUB ? ALU_SUB : op == OP_OR  ? ALU_OR  : op == OP_SLT ? ALU_SLT :
           op == OP_SLL ? ALU_SLL : op == OP_SRL ? ALU_SRL : ALU_ADD;
  endfunction
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: run/instruction inputs and datapath control outputs of the control unit
interface control_unit_if #(parameter int DW = 16);
  logic          run;
  logic [DW-1:0] din;
  logic [7:0]    rout;
  logic [7:0]    rin;
  logic          dinout;
  logic          gout;
  logic          ain;
  logic          gin;
  logic [2:0]    alu_op;
  logic          done;
  modport master (output run, din, input rout, rin, dinout, gout, ain, gin, alu_op, done);
  modport slave  (input run, din, output rout, rin, dinout, gout, ain, gin, alu_op, done);
endinterface

// File: rtl/dec3to8.sv
// dec3to8: 3-to-8 one-hot decoder with enable
module dec3to8 (
  input  logic [2:0] w_i,
  input  logic       en_i,
  output logic [7:0] y_o
);
  assign y_o = en_i ? 8'd1 << w_i : 8'd0;
endmodule

// File: rtl/control_unit.sv
// control_unit: T0-T3 FSM sequencing register moves and ALU ops over a shared bus
module control_unit
  import proc_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Run,
  input  logic [DW-1:0] DIN,
  output logic [7:0]    Rout,
  output logic [7:0]    Rin,
  output logic          DINout,
  output logic          Gout,
  output logic          Ain,
  output logic          Gin,
  output logic [2:0]    AluOp,
  output logic          Done
);
  logic [1:0] state_q, state_d;
  logic [9:0] ir_q, ir_d;
  logic [3:0] op;
  logic [2:0] rx, ry, rout_sel;
  logic       t1, t2, t3, alu, mv, mvi, rout_en, rin_en;
  logic       unused_din;
  assign op = ir_q[9:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];
  assign alu = is_alu(op);
  assign mv = op == OP_MV;
  assign mvi = op == OP_MVI;
  assign t1 = state_q == T1;
  assign t2 = state_q == T2;
  assign t3 = state_q == T3;
  assign unused_din = ^DIN;
  always_comb begin
    state_d = state_q == T0 ? (Run ? T1 : T0) : t1 ? (alu ? T2 : T0) : t2 ? T3 : T0;
    ir_d = state_q == T0 && Run ? DIN[9:0] : ir_q;
  end
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= T0;
      ir_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
    end
  end
  // ALU ops read Rx in T1 and Ry in T2, so Rx==Ry never needs two drivers at once
  assign rout_en = (t1 && (mv || alu)) || t2;
  assign rout_sel = t1 && alu ? rx : ry;
  assign rin_en = (t1 && (mv || mvi)) || t3;
  dec3to8 u_rout (.w_i(rout_sel), .en_i(rout_en), .y_o(Rout));
  dec3to8 u_rin  (.w_i(rx),       .en_i(rin_en),  .y_o(Rin));
  assign DINout = t1 && mvi;
  assign Ain = t1 && alu;
  assign Gin = t2;
  assign Gout = t3;
  assign AluOp = t2 ? alu_code(op) : ALU_ADD;
  assign Done = (t1 && !alu) || t3;
endmodule
